// File: rtl/debug_controller.sv
// rtl/debug_controller.sv - CPU-domain debug command executor (halt/run/step/reg/mem)
module debug_controller #(
  parameter bit START_HALTED = 1'b0,
  parameter int TIMEOUT      = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  dbg_addr,
  input  logic [31:0] dbg_din,
  input  logic        dbg_wr_en,
  input  logic        dbg_req,
  output logic [31:0] dbg_dout,
  output logic        dbg_ack,
  output logic        cpu_run,
  output logic        cpu_step,
  input  logic        cpu_halted,
  output logic [3:0]  reg_sel,
  output logic [31:0] reg_wdata,
  output logic        reg_wr_en,
  input  logic [31:0] reg_rdata,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_access,
  output logic        mem_wr_en,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack
);

  // HALT, RUN and REG_WR do all their work in the launch cycle, so they
  // have no dedicated state; they hand straight over to WAIT_HALT or DONE.
  typedef enum logic [2:0] {
    S_IDLE,
    S_STEP,
    S_SKIP,
    S_WAIT_HALT,
    S_REG_RD,
    S_MEM,
    S_DONE
  } state_t;

  localparam logic [7:0] TMO = TIMEOUT[7:0];

  state_t      state;
  logic [3:0]  cmd;
  logic [31:0] address;
  logic [31:0] data;
  logic        err;
  logic        req_q;
  logic [7:0]  tcnt;

  logic launch;
  assign launch = dbg_req && !req_q;

  // The register file and memory ports are plain views of ADDRESS/DATA.
  assign reg_sel   = address[3:0];
  assign reg_wdata = data;
  assign mem_addr  = {address[31:2], 2'b00};
  assign mem_wdata = data;

  // Debug registers, command FSM and all CPU-side strobes.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      cmd        <= 4'd0;
      address    <= 32'd0;
      data       <= 32'd0;
      err        <= 1'b0;
      req_q      <= 1'b1;   // a request already high at reset release must not launch
      tcnt       <= 8'd0;
      dbg_ack    <= 1'b0;
      cpu_run    <= !START_HALTED;
      cpu_step   <= 1'b0;
      reg_wr_en  <= 1'b0;
      mem_access <= 1'b0;
      mem_wr_en  <= 1'b0;
    end else begin
      req_q     <= dbg_req;
      dbg_ack   <= 1'b0;
      cpu_step  <= 1'b0;
      reg_wr_en <= 1'b0;

      // Host writes come first so an internal DATA capture below overrides them.
      if (dbg_wr_en) begin
        case (dbg_addr)
          2'd0:    cmd     <= dbg_din[3:0];
          2'd1:    address <= dbg_din;
          2'd2:    data    <= dbg_din;
          default: ;
        endcase
      end

      case (state)
        S_IDLE: begin
          if (launch) begin
            err <= 1'b0;
            case (cmd)
              4'd0: begin
                cpu_run <= 1'b0;
                tcnt    <= 8'd0;
                state   <= S_WAIT_HALT;
              end
              4'd1: begin
                cpu_run <= 1'b1;
                state   <= S_DONE;
              end
              4'd2: begin
                if (cpu_halted) begin
                  cpu_step <= 1'b1;
                  state    <= S_STEP;
                end else begin
                  err   <= 1'b1;
                  state <= S_DONE;
                end
              end
              4'd3: begin
                if (cpu_halted) begin
                  state <= S_REG_RD;
                end else begin
                  err   <= 1'b1;
                  state <= S_DONE;
                end
              end
              4'd4: begin
                if (cpu_halted) begin
                  reg_wr_en <= 1'b1;
                end else begin
                  err <= 1'b1;
                end
                state <= S_DONE;
              end
              4'd5, 4'd6: begin
                mem_access <= 1'b1;
                mem_wr_en  <= (cmd == 4'd6);
                tcnt       <= 8'd0;
                state      <= S_MEM;
              end
              default: state <= S_DONE;
            endcase
          end
        end

        // cpu_step is high during this cycle; the next one is the skip cycle.
        S_STEP: state <= S_SKIP;

        S_SKIP: begin
          tcnt  <= 8'd0;
          state <= S_WAIT_HALT;
        end

        S_WAIT_HALT: begin
          if (cpu_halted) begin
            state <= S_DONE;
          end else if (tcnt == TMO) begin
            err   <= 1'b1;
            state <= S_DONE;
          end else begin
            tcnt <= tcnt + 8'd1;
          end
        end

        // reg_sel has been stable since launch, so reg_rdata is valid now.
        S_REG_RD: begin
          data  <= reg_rdata;
          state <= S_DONE;
        end

        // Memory completion acks directly so the ack trails mem_ack by one cycle.
        S_MEM: begin
          if (mem_ack) begin
            if (!mem_wr_en) begin
              data <= mem_rdata;
            end
            mem_access <= 1'b0;
            mem_wr_en  <= 1'b0;
            dbg_ack    <= 1'b1;
            state      <= S_IDLE;
          end else if (tcnt == TMO) begin
            mem_access <= 1'b0;
            mem_wr_en  <= 1'b0;
            err        <= 1'b1;
            dbg_ack    <= 1'b1;
            state      <= S_IDLE;
          end else begin
            tcnt <= tcnt + 8'd1;
          end
        end

        S_DONE: begin
          dbg_ack <= 1'b1;
          state   <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

  // Registered read-back of the register selected by dbg_addr.
  always_ff @(posedge clk) begin
    if (rst) begin
      dbg_dout <= 32'd0;
    end else begin
      case (dbg_addr)
        2'd0:    dbg_dout <= {28'd0, cmd};
        2'd1:    dbg_dout <= address;
        2'd2:    dbg_dout <= data;
        default: dbg_dout <= {30'd0, err, cpu_halted};
      endcase
    end
  end

endmodule

// File: tb/tb_debug_controller.sv
// tb/tb_debug_controller.sv - scoreboard bench for debug_controller
module tb_debug_controller;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  dbg_addr = 2'd0;
  logic [31:0] dbg_din = 32'd0;
  logic        dbg_wr_en = 1'b0;
  logic        dbg_req = 1'b0;
  logic [31:0] dbg_dout;
  logic        dbg_ack;
  logic        cpu_run;
  logic        cpu_step;
  logic        cpu_halted = 1'b0;
  logic [3:0]  reg_sel;
  logic [31:0] reg_wdata;
  logic        reg_wr_en;
  logic [31:0] reg_rdata = 32'd0;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_access;
  logic        mem_wr_en;
  logic [31:0] mem_rdata = 32'd0;
  logic        mem_ack = 1'b0;

  debug_controller dut (
    .clk(clk), .rst(rst),
    .dbg_addr(dbg_addr), .dbg_din(dbg_din), .dbg_wr_en(dbg_wr_en), .dbg_req(dbg_req),
    .dbg_dout(dbg_dout), .dbg_ack(dbg_ack),
    .cpu_run(cpu_run), .cpu_step(cpu_step), .cpu_halted(cpu_halted),
    .reg_sel(reg_sel), .reg_wdata(reg_wdata), .reg_wr_en(reg_wr_en), .reg_rdata(reg_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_access(mem_access),
    .mem_wr_en(mem_wr_en), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  always #5 clk = ~clk;

  typedef struct {
    int   cyc;
    logic run;
  } ack_t;

  ack_t ack_q[$];
  ack_t e;
  int cyc = 0;
  int vectors = 0;
  int miscompares = 0;

  int step_cnt = 0, step_cyc = 0;
  int regwr_cnt = 0;
  logic [31:0] regwr_data = 32'd0;
  int memwr_cnt = 0, memrd_cnt = 0;
  logic [31:0] memwr_addr = 32'd0, memwr_data = 32'd0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops the expected ack on every dbg_ack and tallies CPU-side strobes.
  always @(negedge clk) begin
    if (dbg_ack) begin
      if (ack_q.size() == 0) begin
        chk("unexpected_ack", 32'd1, 32'd0);
      end else begin
        e = ack_q.pop_front();
        chk("ack_cycle", cyc, e.cyc);
        chk("ack_cpu_run", {31'd0, cpu_run}, {31'd0, e.run});
      end
    end
    if (cpu_step) begin
      step_cnt++;
      step_cyc = cyc;
    end
    if (reg_wr_en) begin
      regwr_cnt++;
      regwr_data = reg_wdata;
    end
    if (mem_access && mem_wr_en) begin
      memwr_cnt++;
      memwr_addr = mem_addr;
      memwr_data = mem_wdata;
    end
    if (mem_access && !mem_wr_en) memrd_cnt++;
  end

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    dbg_addr = a; dbg_din = d; dbg_wr_en = 1'b1;
    @(posedge clk); #1;
    dbg_wr_en = 1'b0;
  endtask

  task automatic rd(input string name, input logic [1:0] a, input logic [31:0] exp);
    @(posedge clk); #1;
    dbg_addr = a;
    @(posedge clk);
    @(negedge clk);
    chk(name, dbg_dout, exp);
  endtask

  task automatic launch(input logic [3:0] cmd, input int lat, input logic run,
                        input bit push, output int c);
    ack_t a;
    wr(2'd0, {28'd0, cmd});
    @(posedge clk); #1;
    dbg_req = 1'b1;
    c = cyc;
    if (push) begin
      a.cyc = c + lat;
      a.run = run;
      ack_q.push_back(a);
    end
  endtask

  task automatic finish(input int n);
    repeat (n) @(posedge clk);
    #1 dbg_req = 1'b0;
    @(posedge clk); #1;
    chk("acks_pending", ack_q.size(), 32'd0);
    ack_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int c, n0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_cpu_run", {31'd0, cpu_run}, 32'd1);
    chk("rst_strobes", {27'd0, dbg_ack, cpu_step, reg_wr_en, mem_access, mem_wr_en}, 32'd0);
    chk("rst_dout", dbg_dout, 32'd0);
    @(posedge clk); #1 rst = 1'b0;

    // HALT: cpu_halted rises 5 cycles after launch -> ack at T+7
    launch(4'd0, 7, 1'b0, 1'b1, c);
    repeat (5) @(posedge clk);
    #1 cpu_halted = 1'b1;
    finish(4);
    rd("status_after_halt", 2'd3, 32'h1);

    // REG_RD from GPR 3
    reg_rdata = 32'hDEADBEEF;
    wr(2'd1, 32'd3);
    launch(4'd3, 3, 1'b0, 1'b1, c);
    @(negedge clk);
    chk("reg_sel", {28'd0, reg_sel}, 32'd3);
    finish(4);
    rd("data_after_reg_rd", 2'd2, 32'hDEADBEEF);
    rd("address_readback", 2'd1, 32'd3);

    // REG_WR
    wr(2'd2, 32'h12345678);
    n0 = regwr_cnt;
    launch(4'd4, 2, 1'b0, 1'b1, c);
    finish(4);
    chk("reg_wr_pulses", regwr_cnt - n0, 32'd1);
    chk("reg_wdata", regwr_data, 32'h12345678);

    // MEM write, mem_ack in the third access cycle
    wr(2'd1, 32'h00001003);
    wr(2'd2, 32'hCAFEF00D);
    n0 = memwr_cnt;
    launch(4'd6, 4, 1'b0, 1'b1, c);
    repeat (3) @(posedge clk);
    #1 mem_ack = 1'b1;
    @(posedge clk);
    #1 mem_ack = 1'b0;
    finish(3);
    chk("mem_wr_cycles", memwr_cnt - n0, 32'd3);
    chk("mem_addr", memwr_addr, 32'h00001000);
    chk("mem_wdata", memwr_data, 32'hCAFEF00D);

    // MEM read
    mem_rdata = 32'hA5A5A5A5;
    n0 = memrd_cnt;
    launch(4'd5, 4, 1'b0, 1'b1, c);
    repeat (3) @(posedge clk);
    #1 mem_ack = 1'b1;
    @(posedge clk);
    #1 mem_ack = 1'b0;
    finish(3);
    chk("mem_rd_cycles", memrd_cnt - n0, 32'd3);
    rd("data_after_mem_rd", 2'd2, 32'hA5A5A5A5);

    // MEM read timeout: 256 access cycles, ack right after
    mem_rdata = 32'h11111111;
    n0 = memrd_cnt;
    launch(4'd5, 257, 1'b0, 1'b1, c);
    finish(262);
    chk("timeout_access_cycles", memrd_cnt - n0, 32'd256);
    rd("status_after_timeout", 2'd3, 32'h3);
    rd("data_kept_on_timeout", 2'd2, 32'hA5A5A5A5);

    // RUN, then rejections while running
    launch(4'd1, 2, 1'b1, 1'b1, c);
    finish(3);
    cpu_halted = 1'b0;
    n0 = step_cnt;
    launch(4'd2, 2, 1'b1, 1'b1, c);
    finish(4);
    chk("reject_step_pulses", step_cnt - n0, 32'd0);
    rd("status_reject_step", 2'd3, 32'h2);
    launch(4'd3, 2, 1'b1, 1'b1, c);
    finish(4);
    rd("data_reject_reg_rd", 2'd2, 32'hA5A5A5A5);
    n0 = regwr_cnt;
    launch(4'd4, 2, 1'b1, 1'b1, c);
    finish(4);
    chk("reject_reg_wr_pulses", regwr_cnt - n0, 32'd0);

    // HALT with CPU already halted -> ack at T+3, err cleared
    cpu_halted = 1'b1;
    launch(4'd0, 3, 1'b0, 1'b1, c);
    finish(4);
    rd("status_after_halt2", 2'd3, 32'h1);

    // STEP: pulse at T+1, CPU busy T+2..T+3, halted again at T+4 -> ack T+6
    n0 = step_cnt;
    launch(4'd2, 6, 1'b0, 1'b1, c);
    repeat (2) @(posedge clk);
    #1 cpu_halted = 1'b0;
    repeat (2) @(posedge clk);
    #1 cpu_halted = 1'b1;
    finish(4);
    chk("step_pulses", step_cnt - n0, 32'd1);
    chk("step_cycle", step_cyc, c + 1);

    // no-op command held high 22 cycles: exactly one ack
    launch(4'd9, 2, 1'b0, 1'b1, c);
    finish(22);
    rd("status_noop", 2'd3, 32'h1);

    // reset in the middle of a MEM read, request held across reset release
    launch(4'd5, 0, 1'b0, 1'b0, c);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("rst_mid_mem_access", {31'd0, mem_access}, 32'd0);
    chk("rst_mid_cpu_run", {31'd0, cpu_run}, 32'd1);
    chk("rst_mid_ack", {31'd0, dbg_ack}, 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    finish(10);
    rd("cmd_after_rst", 2'd0, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/debug_controller.md
# debug_controller

CPU-clock-domain debug controller that consumes the four-register command interface driven by the JTAG debug bridge and executes the commands against the CPU core. Supported commands: halt, run, single-step, register read/write and 32-bit memory read/write. The JTAG-to-`clk` synchronisation of `dbg_addr`, `dbg_din`, `dbg_wr_en` and `dbg_req` is done by a separate synchroniser stage, so every input here is synchronous to `clk`. Sits between that synchroniser and the core's run control, register file port and memory arbiter.

## Interface

**Parameters**
- `START_HALTED`, 0: value of the halt state after reset; 1 = CPU held halted.
- `TIMEOUT`, 255: cycles to wait for `cpu_halted` or `mem_ack` before flagging an error (8-bit counter).

**Ports**
- `clk`  in  1  core clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `dbg_addr`  in  2  debug register select: 0 CMD, 1 ADDRESS, 2 DATA, 3 STATUS.
- `dbg_din`  in  32  write data.
- `dbg_wr_en`  in  1  one-cycle write strobe for register `dbg_addr`.
- `dbg_req`  in  1  level command request.
- `dbg_dout`  out  32  registered read of register `dbg_addr`.
- `dbg_ack`  out  1  one-cycle command-complete pulse.
- `cpu_run`  out  1  1 = CPU may execute; 0 = halt request.
- `cpu_step`  out  1  one-cycle pulse: execute one instruction while halted.
- `cpu_halted`  in  1  CPU is quiescent.
- `reg_sel`  out  4  GPR index (ADDRESS[3:0]).
- `reg_wdata`  out  32  GPR write data (DATA).
- `reg_wr_en`  out  1  GPR write strobe.
- `reg_rdata`  in  32  GPR read data; valid the cycle after `reg_sel` is stable.
- `mem_addr`  out  32  memory address (ADDRESS, bits [1:0] forced to 0).
- `mem_wdata`  out  32  memory write data (DATA).
- `mem_access`  out  1  memory request; held until `mem_ack` or timeout.
- `mem_wr_en`  out  1  1 = write; qualifies `mem_access`.
- `mem_rdata`  in  32  read data, valid with `mem_ack`.
- `mem_ack`  in  1  memory completion.

## Operation

**Debug registers**
- `dbg_wr_en` writes `dbg_din` to CMD (addr 0, bits [3:0] kept), ADDRESS (addr 1) or DATA (addr 2).
- STATUS (addr 3) is read-only: {30'b0, err, cpu_halted}.
- When a write strobe and an internal DATA update coincide, the internal update wins.

**Command launch**
- A command launches on a rising edge of `dbg_req` (req=1, registered req=0) while in IDLE.
- An edge seen outside IDLE is dropped and no ack is produced.
- Launch clears `err`.

**States**
- IDLE: wait for a launch, then decode CMD.
- HALT (cmd 0): `cpu_run` <= 0; go to WAIT_HALT.
- RUN (cmd 1): `cpu_run` <= 1; go to DONE.
- STEP (cmd 2):
  - Requires `cpu_halted`.
  - Pulse `cpu_step` for 1 cycle, skip 1 cycle, then go to WAIT_HALT.
- WAIT_HALT: go to DONE when `cpu_halted`. On timeout, set `err` and go to DONE.
- REG_RD (cmd 3): drive `reg_sel`; the next cycle, DATA <= `reg_rdata`; go to DONE.
- REG_WR (cmd 4): `reg_wr_en` for 1 cycle; go to DONE.
- MEM (cmd 5 read, cmd 6 write):
  - Hold `mem_access` (and `mem_wr_en` for writes) until `mem_ack`.
  - On a read, capture DATA <= `mem_rdata` with the ack.
  - On timeout, drop `mem_access`, set `err`, and leave DATA unchanged.
- DONE: `dbg_ack` = 1 for one cycle; return to IDLE.

**Rejections**
- STEP, REG_RD and REG_WR with `cpu_halted`=0 set `err` and go directly to DONE with no CPU side effect.
- cmd 7–15 go directly to DONE (no-op, no error).
- Memory commands are allowed while the CPU is running; arbitration is the memory arbiter's job.

**Timeout**
- The counter clears on entry to WAIT_HALT or MEM and increments each cycle in that state.
- Timeout fires when the counter equals `TIMEOUT`.

## Timing

**Reset values**
- `cpu_run` = !START_HALTED.
- `dbg_ack`, `cpu_step`, `reg_wr_en`, `mem_access`, `mem_wr_en` = 0.
- `dbg_dout` = 0; CMD/ADDRESS/DATA = 0; `err` = 0; state IDLE.
- Registered req = 1 at reset, so a request already high at reset release does not launch.

**Latency** (launch edge at cycle T)
- RUN: ack at T+2.
- HALT with CPU already halted: ack at T+3.
- REG_WR: strobe at T+1, ack at T+2.
- REG_RD: sel from T+1, DATA updated at T+2, ack at T+3.
- MEM: `mem_access` from T+1; ack 1 cycle after `mem_ack`.
- Rejections: ack at T+2.

**Other timing rules**
- `dbg_dout` is the register selected by `dbg_addr`, delayed 1 cycle; it reflects a DATA update in the cycle after the update.
- `rst` mid-command aborts immediately:
  - Outputs return to reset values in the next cycle.
  - No ack is produced.
  - `mem_access` drops even without `mem_ack`.
- `dbg_req` dropping mid-command does not abort; the ack is still produced.

## Test plan

- Reset with START_HALTED=0 -> `cpu_run`=1, all strobes 0. Write CMD=0, raise `dbg_req`, `cpu_halted` rises 5 cycles later -> `cpu_run`=0, one `dbg_ack` pulse, STATUS=0x1.
- Halted CPU; ADDRESS=3, CMD=3, `reg_rdata`=0xDEADBEEF -> `reg_sel`=3, ack at T+3, reading addr 2 returns 0xDEADBEEF. Repeat with CMD=4, DATA=0x12345678 -> exactly one `reg_wr_en` with `reg_wdata`=0x12345678.
- ADDRESS=0x1003, DATA=0xCAFEF00D, CMD=6, `mem_ack` after 3 cycles -> `mem_addr`=0x1000, `mem_wr_en`=1 for those cycles, ack 1 cycle after `mem_ack`; CMD=5 with `mem_rdata`=0xA5A5A5A5 -> DATA=0xA5A5A5A5.
- CMD=5 with `mem_ack` never asserted, TIMEOUT=255 -> `mem_access` drops after timeout, ack follows, STATUS=0x2|halted, DATA unchanged.
- CPU running; CMD=2 and CMD=3 -> no `cpu_step`/`reg_*` activity, ack at T+2, err=1. Halted; CMD=2 -> one `cpu_step` pulse, ack after `cpu_halted` re-asserts.
- Hold `dbg_req` high for 20 cycles after an ack -> no second command. Assert `rst` mid MEM -> `mem_access`=0 next cycle, no ack, `cpu_run` back to reset value.
